// File: rtl/sram_6116_gen.sv
// Synchronous 6116-style static RAM/ROM with active-low pin interface, configurable read latency
// and a post-reset clear-fill sequence that writes INIT_VAL to every word before accesses are accepted.
module sram_6116_gen #(
  parameter int unsigned           DATA_W   = 8,
  parameter int unsigned           ADDR_W   = 11,
  parameter int unsigned           READ_LAT = 1,
  parameter logic [DATA_W-1:0]     INIT_VAL = '0,
  parameter bit                    WRITABLE = 1'b1
) (
  input  logic              phi0,
  input  logic              reset,
  input  logic [DATA_W-1:0] Din,
  output logic [DATA_W-1:0] Dout,
  input  logic [ADDR_W-1:0] A,
  input  logic              CS_b,
  input  logic              WE_b,
  input  logic              OE_b,
  output logic              ready,
  output logic              rvalid,
  output logic              wr_blocked
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_addr;
  logic              clr_we;
  logic              mem_we;
  logic              rd_req;
  logic              wr_req;
  logic              blk_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] pipe_data [READ_LAT];
  logic [READ_LAT-1:0] pipe_vld;

  // State register
  always_ff @(posedge phi0) begin
    if (reset) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: leave CLEAR on the edge that fills the last word
  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clr_addr == '1) begin
      state_nxt = RUN;
    end
  end

  // Output / decode logic
  always_comb begin
    ready   = (state == RUN);
    wr_req  = ~CS_b & ~WE_b;
    clr_we  = ~reset & (state == CLEAR);
    mem_we  = ~reset & (state == RUN) & wr_req & WRITABLE;
    rd_req  = ~reset & (state == RUN) & ~CS_b & ~OE_b & WE_b;
    blk_nxt = wr_req & ((state == CLEAR) | ~WRITABLE);
  end

  always_ff @(posedge phi0) begin
    if (reset) begin
      clr_addr   <= '0;
      wr_blocked <= 1'b0;
    end else begin
      wr_blocked <= blk_nxt;
      if (state == CLEAR) begin
        clr_addr <= clr_addr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge phi0) begin
    if (clr_we) begin
      mem[clr_addr] <= INIT_VAL;
    end else if (mem_we) begin
      mem[A] <= Din;
    end
  end

  // Read pipeline: stage 0 captures the array at the sampling edge, later stages just delay it
  always_ff @(posedge phi0) begin
    if (reset) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= rd_req;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
      end
    end
  end

  always_ff @(posedge phi0) begin
    if (rd_req) begin
      pipe_data[0] <= mem[A];
    end
    for (int unsigned i = 1; i < READ_LAT; i++) begin
      pipe_data[i] <= pipe_data[i-1];
    end
  end

  assign rvalid = pipe_vld[READ_LAT-1];
  assign Dout   = pipe_vld[READ_LAT-1] ? pipe_data[READ_LAT-1] : 'z;

endmodule
